// File: rtl/decode_execute_skid_register.sv
// Purpose: decode->execute boundary as a 2-entry valid/ready skid buffer with flush and stall counter.
// Latency: 1 cycle IN->OUT when empty; sustains 1 bundle/cycle while OUT_READY is held high.
// Backpressure: IN_READY comes straight from a flop (low only when the skid entry is in use).
module decode_execute_skid_register #(
  parameter int                    DATA_WIDTH  = 160,
  parameter logic [DATA_WIDTH-1:0] CTRL_MASK   = '0,
  parameter int                    COUNT_WIDTH = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   FLUSH,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  input  logic [DATA_WIDTH-1:0]  IN_DATA,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic [DATA_WIDTH-1:0]  OUT_DATA,
  output logic [1:0]             OCCUPANCY,
  input  logic                   CLEAR_COUNT,
  output logic [COUNT_WIDTH-1:0] STALL_CYCLES
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = {COUNT_WIDTH{1'b1}};
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                  state_q, state_d;
  logic                    in_ready_q, in_ready_d;
  logic [DATA_WIDTH-1:0]   main_q, main_d;
  logic [DATA_WIDTH-1:0]   skid_q, skid_d;
  logic [COUNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                    in_fire;
  logic                    out_fire;

  assign in_fire  = IN_VALID & in_ready_q;
  assign out_fire = OUT_VALID & OUT_READY;

  // State, ready flop, storage and counter registers; reset empties both entries.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state: flush always drops to EMPTY; otherwise track how many entries are held.
  always_comb begin
    state_d = state_q;
    if (FLUSH) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (in_fire) state_d = ST_BUSY;
        ST_BUSY: begin
          if (in_fire && !out_fire)      state_d = ST_FULL;
          else if (!in_fire && out_fire) state_d = ST_EMPTY;
        end
        ST_FULL:  if (out_fire) state_d = ST_BUSY;
        default:  state_d = ST_EMPTY;
      endcase
    end
    // Ready for next cycle is known now, so the output is a plain flop.
    in_ready_d = (state_d != ST_FULL);
  end

  // Storage loads: main feeds execute, skid catches the bundle accepted while execute stalls.
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (FLUSH) begin
      // Kill side effects of the bundle left on OUT_DATA; payload bits just hold.
      main_d = main_q & ~CTRL_MASK;
    end else begin
      case (state_q)
        ST_EMPTY: if (in_fire) main_d = IN_DATA;
        ST_BUSY: begin
          if (in_fire && out_fire) main_d = IN_DATA;
          else if (in_fire)        skid_d = IN_DATA;
        end
        ST_FULL:  if (out_fire) main_d = skid_q;
        default:  main_d = main_q;
      endcase
    end
  end

  // Saturating back-pressure counter; clear wins, flush has no effect on it.
  always_comb begin
    cnt_d = cnt_q;
    if (CLEAR_COUNT) begin
      cnt_d = '0;
    end else if (OUT_VALID && !OUT_READY && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Outputs decoded from the registered state and storage.
  always_comb begin
    OUT_VALID = 1'b0;
    OCCUPANCY = 2'd0;
    case (state_q)
      ST_BUSY: begin
        OUT_VALID = 1'b1;
        OCCUPANCY = 2'd1;
      end
      ST_FULL: begin
        OUT_VALID = 1'b1;
        OCCUPANCY = 2'd2;
      end
      default: begin
        OUT_VALID = 1'b0;
        OCCUPANCY = 2'd0;
      end
    endcase
    IN_READY     = in_ready_q;
    OUT_DATA     = main_q;
    STALL_CYCLES = cnt_q;
  end

endmodule

// File: tb/tb_decode_execute_skid_register.sv
// Bench for decode_execute_skid_register: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed values, then a randomized soak.
// Uses a 16-bit payload, top nibble as control bits, and a 4-bit stall counter.
module tb_decode_execute_skid_register;

  localparam int          DW   = 16;
  localparam int          CW   = 4;
  localparam logic [15:0] MASK = 16'hF000;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          FLUSH = 1'b0;
  logic          IN_VALID = 1'b0;
  logic          IN_READY;
  logic [DW-1:0] IN_DATA = '0;
  logic          OUT_VALID;
  logic          OUT_READY = 1'b0;
  logic [DW-1:0] OUT_DATA;
  logic [1:0]    OCCUPANCY;
  logic          CLEAR_COUNT = 1'b0;
  logic [CW-1:0] STALL_CYCLES;

  int errors = 0;
  int checks = 0;
  bit run = 0;

  decode_execute_skid_register #(
    .DATA_WIDTH (DW),
    .CTRL_MASK  (MASK),
    .COUNT_WIDTH(CW)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .FLUSH       (FLUSH),
    .IN_VALID    (IN_VALID),
    .IN_READY    (IN_READY),
    .IN_DATA     (IN_DATA),
    .OUT_VALID   (OUT_VALID),
    .OUT_READY   (OUT_READY),
    .OUT_DATA    (OUT_DATA),
    .OCCUPANCY   (OCCUPANCY),
    .CLEAR_COUNT (CLEAR_COUNT),
    .STALL_CYCLES(STALL_CYCLES)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an ordered queue of held bundles, the value shown when empty, a counter.
  logic [15:0] mq[$];
  logic [15:0] m_held;
  int          m_cnt;
  int          m_n;
  logic [15:0] m_pre;
  bit          m_in_fire, m_out_fire;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      mq.delete();
      m_held = 16'h0;
      m_cnt  = 0;
    end else begin
      m_n        = mq.size();
      m_pre      = (m_n > 0) ? mq[0] : m_held;
      m_in_fire  = IN_VALID && (m_n < 2);
      m_out_fire = (m_n > 0) && OUT_READY;
      if (CLEAR_COUNT) m_cnt = 0;
      else if (m_n > 0 && !OUT_READY && m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
      if (FLUSH) begin
        mq.delete();
        m_held = m_pre & ~MASK;
      end else begin
        if (m_out_fire) void'(mq.pop_front());
        if (m_in_fire) mq.push_back(IN_DATA);
        if (mq.size() == 0) m_held = m_pre;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  logic [15:0] exp_data;
  always @(negedge CLK) begin
    if (run && !RST) begin
      if (mq.size() > 0) exp_data = mq[0];
      else exp_data = m_held;
      chk("model_out_valid", {31'd0, OUT_VALID}, {31'd0, mq.size() != 0});
      chk("model_in_ready", {31'd0, IN_READY}, {31'd0, mq.size() < 2});
      chk("model_occupancy", {30'd0, OCCUPANCY}, mq.size());
      chk("model_out_data", {16'd0, OUT_DATA}, {16'd0, exp_data});
      chk("model_stall_cycles", {28'd0, STALL_CYCLES}, m_cnt);
    end
  end

  task automatic step(input logic iv, input logic [15:0] id, input logic ord,
                      input logic fl, input logic clr);
    IN_VALID    = iv;
    IN_DATA     = id;
    OUT_READY   = ord;
    FLUSH       = fl;
    CLEAR_COUNT = clr;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_outs(input string nm, input logic v, input logic r, input logic [1:0] occ,
                          input logic [15:0] d);
    chk({nm, "_valid"}, {31'd0, OUT_VALID}, {31'd0, v});
    chk({nm, "_ready"}, {31'd0, IN_READY}, {31'd0, r});
    chk({nm, "_occ"}, {30'd0, OCCUPANCY}, {30'd0, occ});
    chk({nm, "_data"}, {16'd0, OUT_DATA}, {16'd0, d});
  endtask

  initial begin
    // Reset values while RST is held.
    @(posedge CLK); #1;
    chk_outs("reset", 1'b0, 1'b1, 2'd0, 16'h0);
    chk("reset_cnt", {28'd0, STALL_CYCLES}, 32'd0);
    #2 RST = 1'b0;
    run = 1;

    // Stream: 1..8 back to back with execute always ready.
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 16'(i), 1'b1, 1'b0, 1'b0);
      chk_outs("stream", 1'b1, 1'b1, 2'd1, 16'(i));
    end
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    chk_outs("stream_drain", 1'b0, 1'b1, 2'd0, 16'h0008);
    chk("stream_cnt", {28'd0, STALL_CYCLES}, 32'd0);

    // Back-pressure: A then B while stalled, then release.
    step(1'b1, 16'h1A11, 1'b0, 1'b0, 1'b0);
    chk_outs("bp_a", 1'b1, 1'b1, 2'd1, 16'h1A11);
    step(1'b1, 16'h2B22, 1'b0, 1'b0, 1'b0);
    chk_outs("bp_full", 1'b1, 1'b0, 2'd2, 16'h1A11);
    step(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0);  // not accepted: IN_READY was 0
    chk_outs("bp_hold", 1'b1, 1'b0, 2'd2, 16'h1A11);
    chk("bp_cnt2", {28'd0, STALL_CYCLES}, 32'd2);
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    chk_outs("bp_b", 1'b1, 1'b1, 2'd1, 16'h2B22);
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    chk_outs("bp_done", 1'b0, 1'b1, 2'd0, 16'h2B22);
    chk("bp_cnt_final", {28'd0, STALL_CYCLES}, 32'd2);

    // Flush while full with a bundle C offered.
    step(1'b1, 16'hF123, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'hF456, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h7C77, 1'b0, 1'b1, 1'b0);
    chk_outs("flush_full", 1'b0, 1'b1, 2'd0, 16'h0123);
    chk("flush_cnt", {28'd0, STALL_CYCLES}, 32'd4);
    // Flush while busy with C actually handshaking: C must be dropped.
    step(1'b1, 16'hF999, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h7C77, 1'b0, 1'b1, 1'b0);
    chk_outs("flush_busy", 1'b0, 1'b1, 2'd0, 16'h0999);
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    chk_outs("flush_noc", 1'b0, 1'b1, 2'd0, 16'h0999);

    // Asynchronous reset pulsed between edges while full.
    step(1'b1, 16'h3131, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h3232, 1'b0, 1'b0, 1'b0);
    chk_outs("pre_rst_full", 1'b1, 1'b0, 2'd2, 16'h3131);
    #2 RST = 1'b1;
    #1;
    chk_outs("async_rst", 1'b0, 1'b1, 2'd0, 16'h0);
    chk("async_rst_cnt", {28'd0, STALL_CYCLES}, 32'd0);
    #3 RST = 1'b0;
    step(1'b1, 16'h0D0D, 1'b1, 1'b0, 1'b0);
    chk_outs("post_rst_d", 1'b1, 1'b1, 2'd1, 16'h0D0D);
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);

    // Counter saturation and clear-vs-stall priority.
    step(1'b1, 16'h5555, 1'b0, 1'b0, 1'b0);
    repeat (20) step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("cnt_sat", {28'd0, STALL_CYCLES}, 32'd15);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    chk("cnt_clear", {28'd0, STALL_CYCLES}, 32'd0);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("cnt_restart", {28'd0, STALL_CYCLES}, 32'd1);
    chk("cnt_data_stable", {16'd0, OUT_DATA}, 32'h5555);
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);

    // Randomized soak against the model.
    for (int i = 0; i < 10000; i++) begin
      step($urandom_range(3, 0) != 0, 16'($urandom), $urandom_range(3, 0) != 0,
           $urandom_range(31, 0) == 0, $urandom_range(63, 0) == 0);
    end
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    chk_outs("final_drain", 1'b0, 1'b1, 2'd0, OUT_DATA);
    @(negedge CLK);
    run = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
